rr_burst_arb: RTL and testbench
===============================

# rr_burst_arb

Round-robin arbiter that shares one multi-beat resource, such as a bus port or memory channel, among `WIDTH` requesters. Each grant is locked for a whole transaction: it is held until the granted requester completes a beat marked `last`. Between transactions, priority rotates starting after the most recent winner. An optional hold-timeout stops a stalled owner from monopolising the resource.

## Interface
Parameters:
- `WIDTH`, 4: number of requesters (≥2).
- `HOLD_MAX`, 16: maximum cycles a grant may be held; used only when `ARB_TIMEOUT_EN` is defined (≥1).

Ports:
- `clk`  in  1  single clock; all logic is rising-edge.
- `reset_n`  in  1  synchronous, active-low reset.
- `request`  in  `WIDTH`  per-requester request; also acts as beat-valid while that requester is granted.
- `last`  in  `WIDTH`  requester i's current beat is its final beat; sampled only when i is granted.
- `res_ready`  in  1  shared resource accepts a beat this cycle.
- `grant`  out  `WIDTH`  registered one-hot grant, or all zero.
- `grant_id`  out  `$clog2(WIDTH)`  binary index of the current or most recent owner.
- `busy`  out  1  high in HOLD state; equals `|grant`.
- `beat_fire`  out  1  combinational: `|(grant & request) & res_ready`.
- `timeout_evt`  out  1  one-cycle pulse on a forced release. Present only with `ARB_TIMEOUT_EN`.

## Operation
- Two-state FSM:
  - IDLE: `grant`=0.
  - HOLD: exactly one `grant` bit set.
- Rotation pointer `ptr` (`$clog2(WIDTH)` bits) holds the last winner. The search order is `ptr+1, ptr+2, …, ptr+WIDTH`, modulo `WIDTH`, with wrap from `WIDTH-1` to 0. `ptr` itself is checked last.
- IDLE with `|request`=1:
  - the first set bit in search order wins;
  - next state is HOLD;
  - `grant` becomes the winner's one-hot and `grant_id`/`ptr` take the winner index.
- IDLE with `request`=0: remain in IDLE; `ptr` is unchanged.
- HOLD:
  - A beat transfers when `request[grant_id] & res_ready`.
  - A transfer with `last[grant_id]`=1 ends the transaction: next state is IDLE and `grant` becomes 0.
  - If the owner deasserts `request` mid-transaction, the grant is still held; this is a stall, not a release.
  - Requests from other requesters are ignored during HOLD.
  - `last` bits of non-granted requesters are ignored.
- No back-to-back grants: there is always exactly one IDLE cycle between transactions. This is the fixed arbitration bubble.
- Reset, applied at any time including mid-transaction, forces on the next edge:
  - IDLE state;
  - `grant`=0, `grant_id`=0, `busy`=0, `timeout_evt`=0;
  - `ptr`=`WIDTH-1`, so requester 0 has first priority;
  - hold counter=0.
  - An interrupted transaction is discarded silently.

## Timing
- Request arbitration latency: a request seen in IDLE on edge N produces `grant` valid after edge N (visible in cycle N+1).
- Release latency: a last-beat transfer in cycle M gives `grant`=0 in cycle M+1. The next grant is visible in cycle M+2 at the earliest.
- `beat_fire` is combinational and has no register delay.
- `grant`, `grant_id`, `busy` and `timeout_evt` are registered.
- Single requester continuously asserting: granted every other transaction slot, i.e. a one-cycle bubble between its transactions.
- Simultaneous last beat and timeout expiry in the same cycle: normal completion takes precedence and `timeout_evt` stays 0.

## Configuration
- `ARB_TIMEOUT_EN` defined:
  - A hold counter clears on entry to HOLD and increments every HOLD cycle.
  - Forced release happens in the HOLD cycle where the counter equals `HOLD_MAX-1` and no last-beat transfer occurs. Next state is IDLE, `grant`=0, and `timeout_evt`=1 for one cycle.
  - `ptr` keeps the timed-out owner, so that owner gets lowest priority next.
- `ARB_TIMEOUT_EN` undefined:
  - No counter and no `timeout_evt` port.
  - A grant is held indefinitely until a last-beat transfer.

## Test plan
Unless noted, `WIDTH`=4, `res_ready`=1, and `HOLD_MAX`=4 for the timeout build.
- **Reset:** `reset_n`=0 for 2 cycles with `request`=4'b1111 → `grant`=0, `busy`=0, `grant_id`=0. After release, the first grant is 4'b0001, one cycle later.
- **Rotation:** `request`=4'b1111 held; each owner asserts `last` on its first beat → grant sequence 0001, 0000, 0010, 0000, 0100, 0000, 1000, 0000, 0001 (wrap).
- **Lock:** owner 1 runs a 3-beat transaction; `request[0]` and `request[3]` are asserted throughout → `grant`=4'b0010 for 3 cycles. Then 0000. Then 4'b1000, since 3 comes before 0 after ptr=1.
- **Stall:** owner 2 granted; `res_ready`=0 for 5 cycles, then `last` transfers → grant held for all 6 cycles and `beat_fire` is high only in the final cycle. With `ARB_TIMEOUT_EN`, `timeout_evt` pulses after 4 HOLD cycles and the next winner is 3.
- **Mid-transaction reset:** `reset_n`=0 during owner 2's second beat → `grant`=0 on the next edge, and after release requester 0 wins first.
- **Simultaneous events (timeout build):** `last` transfer lands exactly in the `HOLD_MAX`-th HOLD cycle → normal release and `timeout_evt`=0.

Source files
------------

// File: rtl/rr_burst_arb.sv
// Round-robin arbiter granting a shared multi-beat resource for whole transactions.
// Define ARB_TIMEOUT_EN to add the hold-timeout forced release and the timeout_evt output.
module rr_burst_arb #(
    parameter int WIDTH    = 4,
    parameter int HOLD_MAX = 16
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [WIDTH-1:0]         request,
    input  logic [WIDTH-1:0]         last,
    input  logic                     res_ready,
    output logic [WIDTH-1:0]         grant,
    output logic [$clog2(WIDTH)-1:0] grant_id,
    output logic                     busy,
`ifdef ARB_TIMEOUT_EN
    output logic                     beat_fire,
    output logic                     timeout_evt
`else
    output logic                     beat_fire
`endif
);

    localparam int IDW = $clog2(WIDTH);

    if (WIDTH < 2 || HOLD_MAX < 1) begin : g_bad_cfg
        $error("rr_burst_arb: WIDTH must be >= 2 and HOLD_MAX >= 1");
    end

    typedef enum logic {IDLE, HOLD} state_t;

    state_t         state;
    logic [IDW-1:0] ptr;
    logic [IDW-1:0] win_idx;
    logic [IDW-1:0] cand;
    logic           win_found;
    logic           xfer;
    logic           done;

    // Search starts just after the last winner, so the last winner is checked last.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int k = 1; k <= WIDTH; k++) begin
            cand = IDW'((int'(ptr) + k) % WIDTH);
            if (!win_found && request[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    assign xfer      = (state == HOLD) && request[grant_id] && res_ready;
    assign done      = xfer && last[grant_id];
    assign beat_fire = (|(grant & request)) & res_ready;

`ifdef ARB_TIMEOUT_EN
    localparam int CW = $clog2(HOLD_MAX) + 1;
    logic [CW-1:0] hold_cnt;
    logic          expired;

    assign expired = (hold_cnt == CW'(HOLD_MAX - 1));
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= IDLE;
            grant    <= '0;
            grant_id <= '0;
            busy     <= 1'b0;
            ptr      <= IDW'(WIDTH - 1);
`ifdef ARB_TIMEOUT_EN
            hold_cnt    <= '0;
            timeout_evt <= 1'b0;
`endif
        end else begin
`ifdef ARB_TIMEOUT_EN
            timeout_evt <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (win_found) begin
                        state    <= HOLD;
                        grant    <= WIDTH'(1) << win_idx;
                        grant_id <= win_idx;
                        ptr      <= win_idx;
                        busy     <= 1'b1;
`ifdef ARB_TIMEOUT_EN
                        hold_cnt <= '0;
`endif
                    end
                end
                HOLD: begin
`ifdef ARB_TIMEOUT_EN
                    hold_cnt <= hold_cnt + CW'(1);
`endif
                    // A completed last beat wins over a timeout expiring in the same cycle.
                    if (done) begin
                        state <= IDLE;
                        grant <= '0;
                        busy  <= 1'b0;
                    end
`ifdef ARB_TIMEOUT_EN
                    else if (expired) begin
                        state       <= IDLE;
                        grant       <= '0;
                        busy        <= 1'b0;
                        timeout_evt <= 1'b1;
                    end
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rr_burst_arb.sv
// Testbench for rr_burst_arb: vector table, corner-case sequences and a randomized model comparison.
module tb_rr_burst_arb;

    localparam int WIDTH    = 4;
    localparam int HOLD_MAX = 4;

    logic             clk;
    logic             reset_n;
    logic [WIDTH-1:0] request;
    logic [WIDTH-1:0] last;
    logic             res_ready;
    logic [WIDTH-1:0] grant;
    logic [1:0]       grant_id;
    logic             busy;
    logic             beat_fire;
`ifdef ARB_TIMEOUT_EN
    logic             timeout_evt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    rr_burst_arb #(.WIDTH(WIDTH), .HOLD_MAX(HOLD_MAX)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .request    (request),
        .last       (last),
        .res_ready  (res_ready),
        .grant      (grant),
        .grant_id   (grant_id),
        .busy       (busy),
`ifdef ARB_TIMEOUT_EN
        .beat_fire  (beat_fire),
        .timeout_evt(timeout_evt)
`else
        .beat_fire  (beat_fire)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst_n;
        logic [3:0] req;
        logic [3:0] lst;
        logic       rdy;
        logic [3:0] exp_grant;
        logic [1:0] exp_id;
        logic       exp_bf;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic r, input logic [3:0] q, input logic [3:0] l, input logic rd,
                       input logic [3:0] g, input logic [1:0] id, input logic bf);
        vec_t v;
        v.rst_n = r; v.req = q; v.lst = l; v.rdy = rd;
        v.exp_grant = g; v.exp_id = id; v.exp_bf = bf;
        tbl.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Drive one cycle of inputs on the falling edge; outputs are then sampled mid-cycle.
    task automatic step(input logic r, input logic [3:0] q, input logic [3:0] l, input logic rd);
        @(negedge clk);
        reset_n   = r;
        request   = q;
        last      = l;
        res_ready = rd;
        #1;
    endtask

    // Reference model: who owns the resource, who won last, how long the owner has held it.
    int m_owner;
    int m_prev;
    int m_id;
    int m_held;
    bit m_evt;

    task automatic model_check(input int cyc);
        logic [3:0] eg;
        logic       ebf;
        eg  = (m_owner >= 0) ? 4'(1 << m_owner) : 4'd0;
        ebf = (m_owner >= 0) && request[m_owner] && res_ready;
        chk($sformatf("rand%0d_grant", cyc), grant, eg);
        chk($sformatf("rand%0d_id", cyc), grant_id, m_id);
        chk($sformatf("rand%0d_busy", cyc), busy, m_owner >= 0);
        chk($sformatf("rand%0d_beat_fire", cyc), beat_fire, ebf);
`ifdef ARB_TIMEOUT_EN
        chk($sformatf("rand%0d_timeout_evt", cyc), timeout_evt, m_evt);
`endif
    endtask

    task automatic model_edge();
        bit found;
        int c;
        if (!reset_n) begin
            m_owner = -1; m_prev = WIDTH - 1; m_id = 0; m_held = 0; m_evt = 0;
        end else if (m_owner < 0) begin
            m_evt = 0;
            found = 0;
            for (int k = 1; k <= WIDTH; k++) begin
                c = (m_prev + k) % WIDTH;
                if (!found && request[c]) begin
                    found = 1; m_owner = c; m_prev = c; m_id = c; m_held = 0;
                end
            end
        end else begin
            m_evt  = 0;
            m_held = m_held + 1;
            if (request[m_owner] && res_ready && last[m_owner]) begin
                m_owner = -1;
            end
`ifdef ARB_TIMEOUT_EN
            else if (m_held == HOLD_MAX) begin
                m_owner = -1;
                m_evt   = 1;
            end
`endif
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0; request = '0; last = '0; res_ready = 1'b1;

        // Reset, rotation with single-beat transactions, then the lock case.
        add(0, 4'hF, 4'h0, 1, 4'h0, 0, 0);
        add(0, 4'hF, 4'h0, 1, 4'h0, 0, 0);
        add(1, 4'hF, 4'hF, 1, 4'h0, 0, 0);
        add(1, 4'hF, 4'hF, 1, 4'h1, 0, 1);
        add(1, 4'hF, 4'hF, 1, 4'h0, 0, 0);
        add(1, 4'hF, 4'hF, 1, 4'h2, 1, 1);
        add(1, 4'hF, 4'hF, 1, 4'h0, 1, 0);
        add(1, 4'hF, 4'hF, 1, 4'h4, 2, 1);
        add(1, 4'hF, 4'hF, 1, 4'h0, 2, 0);
        add(1, 4'hF, 4'hF, 1, 4'h8, 3, 1);
        add(1, 4'hF, 4'hF, 1, 4'h0, 3, 0);
        add(1, 4'hF, 4'hF, 1, 4'h1, 0, 1);
        add(1, 4'h2, 4'h0, 1, 4'h0, 0, 0);
        add(1, 4'hB, 4'h9, 1, 4'h2, 1, 1);
        add(1, 4'hB, 4'h9, 1, 4'h2, 1, 1);
        add(1, 4'hB, 4'hB, 1, 4'h2, 1, 1);
        add(1, 4'h9, 4'h0, 1, 4'h0, 1, 0);
        add(1, 4'h9, 4'h8, 1, 4'h8, 3, 1);
        add(1, 4'h0, 4'h0, 1, 4'h0, 3, 0);

        step(0, 4'h0, 4'h0, 1);
        foreach (tbl[i]) begin
            step(tbl[i].rst_n, tbl[i].req, tbl[i].lst, tbl[i].rdy);
            chk($sformatf("vec%0d_grant", i), grant, tbl[i].exp_grant);
            chk($sformatf("vec%0d_id", i), grant_id, tbl[i].exp_id);
            chk($sformatf("vec%0d_busy", i), busy, |tbl[i].exp_grant);
            chk($sformatf("vec%0d_beat_fire", i), beat_fire, tbl[i].exp_bf);
        end

        // Stall: owner 2 with res_ready low for 5 cycles, others requesting.
        step(1, 4'h4, 4'h0, 1);
        chk("stall_pre_grant", grant, 4'h0);
        for (int i = 0; i < 5; i++) begin
            step(1, 4'hD, 4'h4, 0);
`ifdef ARB_TIMEOUT_EN
            if (i < HOLD_MAX) begin
                chk($sformatf("stall%0d_grant", i), grant, 4'h4);
                chk($sformatf("stall%0d_evt", i), timeout_evt, 1'b0);
            end else begin
                chk($sformatf("stall%0d_grant", i), grant, 4'h0);
                chk($sformatf("stall%0d_evt", i), timeout_evt, 1'b1);
            end
`else
            chk($sformatf("stall%0d_grant", i), grant, 4'h4);
`endif
            chk($sformatf("stall%0d_beat_fire", i), beat_fire, 1'b0);
        end
`ifdef ARB_TIMEOUT_EN
        step(1, 4'h8, 4'h8, 1);
        chk("stall_next_grant", grant, 4'h8);
        chk("stall_next_id", grant_id, 2'd3);
        chk("stall_evt_cleared", timeout_evt, 1'b0);
        step(1, 4'h0, 4'h0, 1);
        chk("stall_end_grant", grant, 4'h0);
`else
        step(1, 4'hD, 4'h4, 1);
        chk("stall_final_grant", grant, 4'h4);
        chk("stall_final_beat_fire", beat_fire, 1'b1);
        step(1, 4'h0, 4'h0, 1);
        chk("stall_end_grant", grant, 4'h0);
        chk("stall_end_id", grant_id, 2'd2);
`endif

        // Reset during owner 2's second beat.
        step(1, 4'h4, 4'h0, 1);
        chk("mrst_pre_grant", grant, 4'h0);
        step(1, 4'h4, 4'h0, 1);
        chk("mrst_beat1_grant", grant, 4'h4);
        chk("mrst_beat1_fire", beat_fire, 1'b1);
        step(0, 4'h4, 4'h0, 1);
        chk("mrst_beat2_grant", grant, 4'h4);
        step(1, 4'hF, 4'h0, 1);
        chk("mrst_after_grant", grant, 4'h0);
        chk("mrst_after_busy", busy, 1'b0);
        chk("mrst_after_id", grant_id, 2'd0);
        step(1, 4'hF, 4'h1, 1);
        chk("mrst_first_winner", grant, 4'h1);
        step(1, 4'h0, 4'h0, 1);
        chk("mrst_release", grant, 4'h0);

        // Last beat lands in the HOLD_MAX-th hold cycle.
        step(1, 4'h2, 4'h0, 1);
        chk("simul_pre_grant", grant, 4'h0);
        for (int i = 0; i < HOLD_MAX; i++) begin
            step(1, 4'h2, (i == HOLD_MAX - 1) ? 4'h2 : 4'h0, 1);
            chk($sformatf("simul%0d_grant", i), grant, 4'h2);
        end
        step(1, 4'h0, 4'h0, 1);
        chk("simul_release_grant", grant, 4'h0);
`ifdef ARB_TIMEOUT_EN
        chk("simul_no_timeout", timeout_evt, 1'b0);
`endif

        // Randomized traffic against the reference model.
        step(0, 4'(($urandom_range(0, 15))), 4'h0, 1);
        model_edge();
        for (int cyc = 0; cyc < 600; cyc++) begin
            step(($urandom_range(0, 59) != 0),
                 4'($urandom_range(0, 15)),
                 4'($urandom_range(0, 15) & $urandom_range(0, 15)),
                 ($urandom_range(0, 3) != 0));
            model_check(cyc);
            model_edge();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
